sd_dat_tx: RTL and testbench

Write-data transmitter controller for the SD data path. It sequences one data block onto the 4-bit DAT bus as start bit, payload, per-line CRC16 and end bit. It owns four CRC16 engines (polynomial x^16 + x^12 + x^5 + 1), one per DAT line: it clears them, feeds them during payload and shifts them out during the CRC phase. It sits between the block buffer (nibble source) and the DAT pad drivers, and the data-transfer FSM in the SD driver starts it.

---
 rtl/sd_dat_tx_if.sv | 21 ++
 rtl/sd_dat_tx.sv | 99 +++++++++
 tb/tb_sd_dat_tx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_dat_tx_if.sv
// Block-buffer / DAT-pad side signals of the SD write-data transmitter.
// master = data source and start requester, slave = transmitter.
interface sd_dat_tx_if;
  logic       istart;
  logic [3:0] inibble;
  logic       onext;
  logic [3:0] odat;
  logic       odat_oe;
  logic       obusy;
  logic       odone;

  modport master (
    output istart, inibble,
    input  onext, odat, odat_oe, obusy, odone
  );

  modport slave (
    input  istart, inibble,
    output onext, odat, odat_oe, obusy, odone
  );
endinterface

// File: rtl/sd_dat_tx.sv
// SD 4-bit write-data transmitter: start bit, payload, per-line CRC16, end bit.
// Owns one CRC16 (x^16+x^12+x^5+1) engine per DAT line.
module sd_dat_tx #(
  parameter int BLOCK_NIBBLES = 1024
) (
  input  logic        iclk,
  input  logic        irst,
  sd_dat_tx_if.slave  bus
);
  localparam int CW = $clog2(BLOCK_NIBBLES + 1);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_NIBBLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_END} state_t;

  state_t        state;
  logic [CW-1:0] nib_cnt;
  logic [3:0]    crc_cnt;
  logic [15:0]   crc [4];
  logic          oe;
  logic          next;
  logic          busy;
  logic          done;
  logic [3:0]    dat;

  // Serial CRC16 update: feedback taps into bits 0, 5 and 12.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    logic fb;
    fb = d ^ c[15];
    return {c[14:12], c[11] ^ fb, c[10:5], c[4] ^ fb, c[3:0], fb};
  endfunction

  always_ff @(posedge iclk) begin
    if (irst) begin
      state   <= S_IDLE;
      nib_cnt <= '0;
      crc_cnt <= '0;
      oe      <= 1'b0;
      next    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int k = 0; k < 4; k++) crc[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.istart) begin
            state <= S_START;
            oe    <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          state   <= S_DATA;
          next    <= 1'b1;
          nib_cnt <= '0;
          crc_cnt <= '0;
          for (int k = 0; k < 4; k++) crc[k] <= '0;
        end
        S_DATA: begin
          nib_cnt <= nib_cnt + 1'b1;
          for (int k = 0; k < 4; k++) crc[k] <= crc_step(crc[k], bus.inibble[k]);
          if (nib_cnt == LAST) begin
            state <= S_CRC;
            next  <= 1'b0;
          end
        end
        S_CRC: begin
          crc_cnt <= crc_cnt + 4'd1;
          for (int k = 0; k < 4; k++) crc[k] <= {crc[k][14:0], 1'b0};
          if (crc_cnt == 4'd15) state <= S_END;
        end
        S_END: begin
          state <= S_IDLE;
          oe    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload passes straight from the buffer to the pads during DATA.
  always_comb begin
    dat = 4'hF;
    case (state)
      S_START: dat = 4'h0;
      S_DATA:  dat = bus.inibble;
      S_CRC:   dat = {crc[3][15], crc[2][15], crc[1][15], crc[0][15]};
      default: dat = 4'hF;
    endcase
  end

  assign bus.odat    = dat;
  assign bus.odat_oe = oe;
  assign bus.onext   = next;
  assign bus.obusy   = busy;
  assign bus.odone   = done;
endmodule

// File: tb/tb_sd_dat_tx.sv
// Bench for sd_dat_tx: vector table, random payloads against a CRC16 reference,
// reset mid-block and continuous-start sequences on three block sizes.
module tb_sd_dat_tx;
  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] nib;
  logic [1:0] sel;

  logic [3:0] o_dat;
  logic       o_oe, o_next, o_busy, o_done;

  int n_chk;
  int n_fail;

  logic [3:0]  pay [$];
  logic [15:0] cap [4];

  sd_dat_tx_if i1 ();
  sd_dat_tx_if i2 ();
  sd_dat_tx_if i3 ();

  sd_dat_tx #(.BLOCK_NIBBLES(1))    u1 (.iclk(clk), .irst(rst), .bus(i1));
  sd_dat_tx #(.BLOCK_NIBBLES(2))    u2 (.iclk(clk), .irst(rst), .bus(i2));
  sd_dat_tx                         u3 (.iclk(clk), .irst(rst), .bus(i3));

  assign i1.istart  = start & (sel == 2'd1);
  assign i2.istart  = start & (sel == 2'd2);
  assign i3.istart  = start & (sel == 2'd3);
  assign i1.inibble = nib;
  assign i2.inibble = nib;
  assign i3.inibble = nib;

  always_comb begin
    o_dat  = i1.odat;
    o_oe   = i1.odat_oe;
    o_next = i1.onext;
    o_busy = i1.obusy;
    o_done = i1.odone;
    case (sel)
      2'd2: begin
        o_dat = i2.odat; o_oe = i2.odat_oe; o_next = i2.onext; o_busy = i2.obusy; o_done = i2.odone;
      end
      2'd3: begin
        o_dat = i3.odat; o_oe = i3.odat_oe; o_next = i3.onext; o_busy = i3.obusy; o_done = i3.odone;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          n;
    logic [3:0]  p0;
    logic [3:0]  p1;
    logic [15:0] c0, c1, c2, c3;
  } vec_t;

  vec_t vt [7];

  localparam logic [7:0] IDLE_OBS = {4'hF, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic logic [7:0] obs();
    return {o_dat, o_oe, o_next, o_busy, o_done};
  endfunction

  // Textbook serial CCITT CRC over one DAT line of the payload.
  function automatic logic [15:0] ref_crc(input int line);
    logic [15:0] c;
    logic        fb;
    c = '0;
    foreach (pay[i]) begin
      fb = pay[i][line] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends one block from IDLE (or the odone cycle) and checks every cycle
  // through the odone cycle; leaves the bench sitting in the odone cycle.
  task automatic run_block(input int n, input bit hold, input bit noise);
    logic [15:0] mc [4];
    for (int k = 0; k < 4; k++) mc[k] = ref_crc(k);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int c = 0; c <= n + 18; c++) begin
      logic [7:0] e;
      int j;
      if (c >= 1 && c <= n) nib = pay[c-1];
      else nib = 4'($urandom);
      if (hold) start = 1'b1;
      else if (noise && c >= 1 && c <= n + 17) start = 1'($urandom);
      else start = 1'b0;
      #1;
      if (c == 0) e = {4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
      else if (c <= n) e = {pay[c-1], 1'b1, 1'b1, 1'b1, 1'b0};
      else if (c <= n + 16) begin
        j = 15 - (c - n - 1);
        e = {mc[3][j], mc[2][j], mc[1][j], mc[0][j], 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) cap[k][j] = o_dat[k];
      end
      else if (c == n + 17) e = {4'hF, 1'b1, 1'b0, 1'b1, 1'b0};
      else e = {4'hF, 1'b0, 1'b0, 1'b0, 1'b1};
      check($sformatf("blk%0d_cyc%0d", n, c), 64'(obs()), 64'(e));
      if (c < n + 18) tick();
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic fill_random(input int n);
    pay = {};
    for (int i = 0; i < n; i++) pay.push_back(4'($urandom));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    nib    = 4'h0;
    sel    = 2'd1;

    vt[0] = '{1, 4'h1, 4'h0, 16'h1021, 16'h0000, 16'h0000, 16'h0000};
    vt[1] = '{1, 4'h2, 4'h0, 16'h0000, 16'h1021, 16'h0000, 16'h0000};
    vt[2] = '{1, 4'hF, 4'h0, 16'h1021, 16'h1021, 16'h1021, 16'h1021};
    vt[3] = '{2, 4'h1, 4'h0, 16'h2042, 16'h0000, 16'h0000, 16'h0000};
    vt[4] = '{2, 4'h0, 4'h1, 16'h1021, 16'h0000, 16'h0000, 16'h0000};
    vt[5] = '{2, 4'hF, 4'hF, 16'h3063, 16'h3063, 16'h3063, 16'h3063};
    vt[6] = '{2, 4'h8, 4'h8, 16'h0000, 16'h0000, 16'h0000, 16'h3063};

    repeat (3) tick();
    for (int s = 1; s <= 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("reset_idle_%0d", s), 64'(obs()), 64'(IDLE_OBS));
    end
    rst = 1'b0;
    tick();

    // Known-answer vectors on the short blocks
    for (int v = 0; v < 7; v++) begin
      sel = 2'(vt[v].n);
      pay = {vt[v].p0};
      if (vt[v].n == 2) pay.push_back(vt[v].p1);
      run_block(vt[v].n, 1'b0, 1'b0);
      check($sformatf("vec%0d_crc", v), {cap[3], cap[2], cap[1], cap[0]},
            {vt[v].c3, vt[v].c2, vt[v].c1, vt[v].c0});
      tick();
    end

    // Random short blocks with start pulses while busy
    sel = 2'd2;
    for (int r = 0; r < 6; r++) begin
      fill_random(2);
      run_block(2, 1'b0, 1'b1);
    end
    tick();

    // Full-size blocks: all-zero payload, then random payload
    sel = 2'd3;
    pay = {};
    for (int i = 0; i < 1024; i++) pay.push_back(4'h0);
    run_block(1024, 1'b0, 1'b0);
    check("zero_blk_crc", {cap[3], cap[2], cap[1], cap[0]}, 64'h0);
    tick();
    fill_random(1024);
    run_block(1024, 1'b0, 1'b1);
    tick();

    // Reset in the middle of DATA
    fill_random(1024);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) begin
      nib = 4'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_data", 64'(obs()), 64'(IDLE_OBS));
    for (int c = 0; c < 30; c++) begin
      nib = 4'($urandom);
      tick();
      check($sformatf("post_rst_idle_%0d", c), 64'(obs()), 64'(IDLE_OBS));
    end
    run_block(1024, 1'b0, 1'b0);
    tick();

    // istart held high: blocks repeat with one odone/IDLE cycle between them
    sel = 2'd1;
    for (int b = 0; b < 4; b++) begin
      fill_random(1);
      run_block(1, 1'b1, 1'b0);
    end
    start = 1'b0;
    tick();
    check("hold_release_idle", 64'(obs()), 64'(IDLE_OBS));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
